// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- next-PC generator for the fetch stage.
//
// Holds the fetch PC. On each rising edge it loads the next PC, picked from
// a fixed-priority set of sources:
//   trap > eret > jalr > jal > branch > replay > stall (hold) > RAS > +INSTR_BYTES
// A circular return-address stack (RAS) predicts return targets at fetch.
// Calls pushed from DX are stored as pc_dx + INSTR_BYTES.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   stall        hold the PC (lowest-priority redirect)
//   trap_valid   redirect to handler_pc; also flushes the RAS
//   handler_pc   trap handler address
//   eret_valid   redirect to epc
//   epc          exception return address
//   jalr_valid   redirect to (rs1_data + jalr_offset) with bit 0 cleared
//   rs1_data     JALR base
//   jalr_offset  JALR offset
//   jal_valid    redirect to pc_dx + jal_offset
//   jal_offset   JAL offset
//   br_taken     redirect to pc_dx + imm_b
//   pc_dx        PC of the DX-stage instruction
//   imm_b        branch offset
//   replay_valid refetch from pc_if
//   pc_if        PC of the IF-stage instruction
//   fetch_ret    instruction at pc_pif is a return (RAS pop/predict request)
//   ras_push     call in DX; push pc_dx + INSTR_BYTES
//   pc_pif       registered fetch PC
//   misalign     registered; pc_pif is not a multiple of INSTR_BYTES
//   ras_pred     registered; pc_pif was loaded from the RAS
//   ras_empty    RAS holds no entries
//   ras_full     RAS holds RAS_DEPTH entries
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] handler_pc,
    input  logic            eret_valid,
    input  logic [XLEN-1:0] epc,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] jalr_offset,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_offset,
    input  logic            br_taken,
    input  logic [XLEN-1:0] pc_dx,
    input  logic [XLEN-1:0] imm_b,
    input  logic            replay_valid,
    input  logic [XLEN-1:0] pc_if,
    input  logic            fetch_ret,
    input  logic            ras_push,
    output logic [XLEN-1:0] pc_pif,
    output logic            misalign,
    output logic            ras_pred,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned     PTR_W          = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W          = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP           = XLEN'(INSTR_BYTES);
    // INSTR_BYTES is a power of two, so its low bits form the alignment mask.
    localparam logic [XLEN-1:0] ALIGN_MASK     = XLEN'(INSTR_BYTES - 1);
    localparam logic            RESET_MISALIGN = (RESET_VECTOR & ALIGN_MASK) != '0;
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(RAS_DEPTH);

    typedef enum logic [3:0] {
        SRC_TRAP,
        SRC_ERET,
        SRC_JALR,
        SRC_JAL,
        SRC_BR,
        SRC_REPLAY,
        SRC_HOLD,
        SRC_RAS,
        SRC_SEQ
    } src_e;

    // RAS state
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] tp;
    logic [CNT_W-1:0] count;

    // Next-state signals
    src_e             src;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  push_val;
    logic             pop;
    logic             push_ok;
    logic [PTR_W-1:0] tp_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_FULL);

    assign jalr_sum = rs1_data + jalr_offset;
    assign push_val = pc_dx + STEP;

    // Source selection. fetch_ret only wins when nothing above it (including
    // stall) is active and the stack has something to predict from.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        src = SRC_SEQ;
        if (trap_valid)                   src = SRC_TRAP;
        else if (eret_valid)              src = SRC_ERET;
        else if (jalr_valid)              src = SRC_JALR;
        else if (jal_valid)               src = SRC_JAL;
        else if (br_taken)                src = SRC_BR;
        else if (replay_valid)            src = SRC_REPLAY;
        else if (stall)                   src = SRC_HOLD;
        else if (fetch_ret && !ras_empty) src = SRC_RAS;
    end

    always_comb begin
        next_pc = pc_pif + STEP;
        case (src)
            SRC_TRAP:   next_pc = handler_pc;
            SRC_ERET:   next_pc = epc;
            SRC_JALR:   next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            SRC_JAL:    next_pc = pc_dx + jal_offset;
            SRC_BR:     next_pc = pc_dx + imm_b;
            SRC_REPLAY: next_pc = pc_if;
            SRC_HOLD:   next_pc = pc_pif;
            SRC_RAS:    next_pc = ras_mem[tp];
            default:    next_pc = pc_pif + STEP;
        endcase
    end

    assign pop     = (src == SRC_RAS);
    assign push_ok = ras_push && !trap_valid;

    // RAS pointer/count update. A simultaneous pop and push replaces the top
    // entry in place, so pointer and occupancy stay where they are. A push
    // into a full stack advances tp onto the oldest entry and overwrites it.
    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = tp;
        if (trap_valid) begin
            tp_nxt    = '0;
            count_nxt = '0;
        end else if (pop && push_ok) begin
            wr_en  = 1'b1;
            wr_idx = tp;
        end else if (push_ok) begin
            tp_nxt    = tp + PTR_W'(1);
            wr_en     = 1'b1;
            wr_idx    = tp + PTR_W'(1);
            count_nxt = ras_full ? count : count + CNT_W'(1);
        end else if (pop) begin
            tp_nxt    = tp - PTR_W'(1);
            count_nxt = count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_pif   <= RESET_VECTOR;
            misalign <= RESET_MISALIGN;
            ras_pred <= 1'b0;
            tp       <= '0;
            count    <= '0;
        end else begin
            pc_pif   <= next_pc;
            misalign <= (next_pc & ALIGN_MASK) != '0;
            ras_pred <= pop;
            tp       <= tp_nxt;
            count    <= count_nxt;
        end
    end

    // NOTE: the stack array is reset explicitly because its contents after
    // reset are defined as zero; with only RAS_DEPTH entries this stays a
    // small flop array rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (wr_en) begin
            ras_mem[wr_idx] <= push_val;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (RESET_VECTOR=0x100, RAS_DEPTH=4).
// A behavioural model (priority chain plus a queue-based return stack) runs
// alongside the DUT; every falling edge compares all outputs against it.
// Directed sequences also check hand-computed literal values, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] handler_pc = '0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = '0;
    logic        jalr_valid = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] jalr_offset = '0;
    logic        jal_valid = 1'b0;
    logic [31:0] jal_offset = '0;
    logic        br_taken = 1'b0;
    logic [31:0] pc_dx = '0;
    logic [31:0] imm_b = '0;
    logic        replay_valid = 1'b0;
    logic [31:0] pc_if = '0;
    logic        fetch_ret = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] pc_pif;
    logic        misalign;
    logic        ras_pred;
    logic        ras_empty;
    logic        ras_full;

    int n_vec = 0;
    int n_err = 0;

    pc_gen #(
        .XLEN        (32),
        .INSTR_BYTES (4),
        .RESET_VECTOR(RV),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .trap_valid  (trap_valid),
        .handler_pc  (handler_pc),
        .eret_valid  (eret_valid),
        .epc         (epc),
        .jalr_valid  (jalr_valid),
        .rs1_data    (rs1_data),
        .jalr_offset (jalr_offset),
        .jal_valid   (jal_valid),
        .jal_offset  (jal_offset),
        .br_taken    (br_taken),
        .pc_dx       (pc_dx),
        .imm_b       (imm_b),
        .replay_valid(replay_valid),
        .pc_if       (pc_if),
        .fetch_ret   (fetch_ret),
        .ras_push    (ras_push),
        .pc_pif      (pc_pif),
        .misalign    (misalign),
        .ras_pred    (ras_pred),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc   = RV;
    logic        m_pred = 1'b0;
    logic        m_mis  = 1'b0;
    logic [31:0] ras_q[$];
    logic [31:0] m_nxt;
    logic        m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc   = RV;
            m_pred = 1'b0;
            m_mis  = (RV % 4) != 0;
            ras_q.delete();
        end else begin
            m_pop = 1'b0;
            if (trap_valid)                       m_nxt = handler_pc;
            else if (eret_valid)                  m_nxt = epc;
            else if (jalr_valid)                  m_nxt = (rs1_data + jalr_offset) & ~32'd1;
            else if (jal_valid)                   m_nxt = pc_dx + jal_offset;
            else if (br_taken)                    m_nxt = pc_dx + imm_b;
            else if (replay_valid)                m_nxt = pc_if;
            else if (stall)                       m_nxt = m_pc;
            else if (fetch_ret && ras_q.size() > 0) begin
                m_nxt = ras_q[$];
                m_pop = 1'b1;
            end else                              m_nxt = m_pc + 32'd4;

            if (trap_valid) begin
                ras_q.delete();
            end else begin
                if (m_pop) void'(ras_q.pop_back());
                if (ras_push) begin
                    ras_q.push_back(pc_dx + 32'd4);
                    if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                end
            end
            m_pc   = m_nxt;
            m_pred = m_pop;
            m_mis  = (m_nxt % 4) != 0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("pc_pif",    pc_pif,           m_pc);
        check("misalign",  32'(misalign),    32'(m_mis));
        check("ras_pred",  32'(ras_pred),    32'(m_pred));
        check("ras_empty", 32'(ras_empty),   32'(ras_q.size() == 0));
        check("ras_full",  32'(ras_full),    32'(ras_q.size() == DEPTH));
    end

    // ---------------- stimulus ----------------
    task automatic clear();
        stall = 0; trap_valid = 0; eret_valid = 0; jalr_valid = 0;
        jal_valid = 0; br_taken = 0; replay_valid = 0; fetch_ret = 0; ras_push = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pc",    pc_pif,          32'h100);
        check("rst_mis",   32'(misalign),   32'd0);
        check("rst_pred",  32'(ras_pred),   32'd0);
        check("rst_empty", 32'(ras_empty),  32'd1);
        check("rst_full",  32'(ras_full),   32'd0);
        rst = 1'b1;

        // sequential fetch
        tick(); check("seq1", pc_pif, 32'h104);
        tick(); check("seq2", pc_pif, 32'h108);
        tick(); check("seq3", pc_pif, 32'h10C);
        check("seq_empty", 32'(ras_empty), 32'd1);

        // priority
        trap_valid = 1; handler_pc = 32'h800; eret_valid = 1; epc = 32'h900;
        jal_valid = 1; pc_dx = 32'h50; jal_offset = 32'h20; stall = 1;
        tick(); check("prio_trap", pc_pif, 32'h800);
        jalr_valid = 1; rs1_data = 32'h201; jalr_offset = 32'h10;
        br_taken = 1; pc_dx = 32'h60; imm_b = 32'h40;
        tick(); check("prio_jalr", pc_pif, 32'h210);

        // stall vs replay
        jal_valid = 1; pc_dx = 32'h30; jal_offset = 32'h10;
        tick(); check("to_40", pc_pif, 32'h40);
        stall = 1; tick(); check("stall1", pc_pif, 32'h40);
        stall = 1; tick(); check("stall2", pc_pif, 32'h40);
        stall = 1; replay_valid = 1; pc_if = 32'h3C;
        tick(); check("replay", pc_pif, 32'h3C);

        // RAS call / return
        ras_push = 1; pc_dx = 32'h1000; tick();
        ras_push = 1; pc_dx = 32'h2000; tick();
        fetch_ret = 1; tick();
        check("ret1", pc_pif, 32'h2004); check("ret1_pred", 32'(ras_pred), 32'd1);
        fetch_ret = 1; tick();
        check("ret2", pc_pif, 32'h1004);
        fetch_ret = 1; tick();
        check("ret3_seq", pc_pif, 32'h1008);
        check("ret3_pred", 32'(ras_pred), 32'd0);
        check("ret3_empty", 32'(ras_empty), 32'd1);

        // overflow: 5 pushes into 4 entries
        for (int i = 0; i < 5; i++) begin
            ras_push = 1; pc_dx = 32'hA000 + 32'(i) * 32'h100; tick();
        end
        check("ovf_full", 32'(ras_full), 32'd1);
        for (int i = 4; i >= 1; i--) begin
            fetch_ret = 1; tick();
            check("ovf_pop", pc_pif, 32'hA004 + 32'(i) * 32'h100);
        end
        check("ovf_empty", 32'(ras_empty), 32'd1);

        // push + pop in the same cycle
        ras_push = 1; pc_dx = 32'h500; tick();
        ras_push = 1; pc_dx = 32'h300; fetch_ret = 1; tick();
        check("pp_old_top", pc_pif, 32'h504);
        check("pp_pred", 32'(ras_pred), 32'd1);
        fetch_ret = 1; tick();
        check("pp_new_top", pc_pif, 32'h304);
        check("pp_empty", 32'(ras_empty), 32'd1);

        // trap flush with simultaneous push
        ras_push = 1; pc_dx = 32'h600; tick();
        trap_valid = 1; handler_pc = 32'hC00; ras_push = 1; pc_dx = 32'h700; tick();
        check("flush_pc", pc_pif, 32'hC00);
        check("flush_empty", 32'(ras_empty), 32'd1);

        // misalign and wrap
        jal_valid = 1; pc_dx = 32'h10; jal_offset = 32'h2; tick();
        check("mis_pc", pc_pif, 32'h12); check("mis_flag", 32'(misalign), 32'd1);
        jal_valid = 1; pc_dx = 32'hFFFF_FFF0; jal_offset = 32'hC; tick();
        check("wrap_pre", pc_pif, 32'hFFFF_FFFC); check("wrap_mis", 32'(misalign), 32'd0);
        tick(); check("wrap", pc_pif, 32'h0);

        // asynchronous reset mid-operation
        ras_push = 1; pc_dx = 32'h800; tick();
        #2 rst = 1'b0;
        #1;
        check("arst_pc", pc_pif, 32'h100);
        check("arst_empty", 32'(ras_empty), 32'd1);
        check("arst_pred", 32'(ras_pred), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(); check("arst_seq", pc_pif, 32'h104);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            trap_valid   = ($urandom_range(31) == 0);
            eret_valid   = ($urandom_range(15) == 0);
            jalr_valid   = ($urandom_range(15) == 0);
            jal_valid    = ($urandom_range(15) == 0);
            br_taken     = ($urandom_range(15) == 0);
            replay_valid = ($urandom_range(15) == 0);
            stall        = ($urandom_range(3) == 0);
            fetch_ret    = ($urandom_range(2) == 0);
            ras_push     = ($urandom_range(3) == 0);
            handler_pc   = $urandom() & 32'hFFFF_FFFC;
            epc          = $urandom();
            rs1_data     = $urandom();
            jalr_offset  = $urandom_range(255);
            jal_offset   = ($urandom_range(7) == 0) ? $urandom() : ($urandom() & 32'hFFC);
            pc_dx        = $urandom() & 32'hFFFF_FFFC;
            imm_b        = $urandom() & 32'h3FFE;
            pc_if        = $urandom();
            @(posedge clk);
            @(negedge clk);
        end
        clear();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
